// File: rtl/msi_bus_controller.sv
// Shared-bus arbiter and main-memory responder for the MSI snooping caches.
// Grants one cache at a time, broadcasts its op/addr and serves Rd/RdX/Upgr/Flush.
module msi_bus_controller #(
  parameter int NUM_CACHES    = 2,
  parameter int MEM_LATENCY   = 4,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CACHES-1:0]    cache_req,
  input  logic [3*NUM_CACHES-1:0]  cache_op,
  input  logic [5*NUM_CACHES-1:0]  cache_addr,
  input  logic [16*NUM_CACHES-1:0] cache_data,
  input  logic [NUM_CACHES-1:0]    cache_done,
  output logic [NUM_CACHES-1:0]    cache_grant,
  output logic [2:0]               bus_op,
  output logic [4:0]               bus_addr,
  output logic [15:0]              bus_data,
  output logic                     bus_done
);

  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_RD    = 3'b001;
  localparam logic [2:0] OP_UPGR  = 3'b010;
  localparam logic [2:0] OP_FLUSH = 3'b011;
  localparam logic [2:0] OP_RDX   = 3'b100;

  typedef enum logic [2:0] {
    Q_ARB, Q_GRANT, Q_UPGR, Q_WRITE, Q_READ, Q_DONE, Q_RELEASE
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [4:0]    lat_addr;
  logic [15:0]   lat_data;
  logic [3:0]    lat_cnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   mem [32];

  logic          arb_hit;
  logic [IW-1:0] arb_idx;
  logic          iv_hit;
  logic [IW-1:0] iv_idx;
  logic [2:0]    g_op;
  logic [4:0]    g_addr;
  logic [15:0]   g_data;
  logic [15:0]   iv_data;
  logic          g_valid;

  // Round-robin: first requester at or above ptr, else first one below it.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!arb_hit && cache_req[i] && IW'(i) >= ptr) begin
        arb_hit = 1'b1;
        arb_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!arb_hit && cache_req[i]) begin
        arb_hit = 1'b1;
        arb_idx = IW'(i);
      end
    end
  end

  // Intervention: lowest-index non-grantee asserting done.
  always_comb begin
    iv_hit = 1'b0;
    iv_idx = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!iv_hit && cache_done[i] && IW'(i) != gidx) begin
        iv_hit = 1'b1;
        iv_idx = IW'(i);
      end
    end
  end

  always_comb begin
    g_op    = cache_op[3*gidx +: 3];
    g_addr  = cache_addr[5*gidx +: 5];
    g_data  = cache_data[16*gidx +: 16];
    iv_data = cache_data[16*iv_idx +: 16];
    g_valid = (g_op == OP_RD) || (g_op == OP_RDX) ||
              (g_op == OP_UPGR) || (g_op == OP_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= Q_ARB;
      ptr         <= '0;
      gidx        <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_cnt     <= '0;
      tcnt        <= '0;
      cache_grant <= '0;
      bus_op      <= OP_NONE;
      bus_addr    <= '0;
      bus_data    <= '0;
      bus_done    <= 1'b0;
      for (int i = 0; i < 32; i++)
        mem[i] <= {3'b000, 5'(i), 3'b000, 5'(i)};
    end else begin
      case (state)
        Q_ARB: begin
          if (arb_hit) begin
            cache_grant <= NUM_CACHES'(1) << arb_idx;
            gidx        <= arb_idx;
            ptr         <= (arb_idx == IW'(NUM_CACHES - 1)) ? '0 : arb_idx + 1'b1;
            tcnt        <= '0;
            state       <= Q_GRANT;
          end
        end
        Q_GRANT: begin
          if (g_valid) begin
            lat_addr <= g_addr;
            lat_data <= g_data;
            lat_cnt  <= 4'(MEM_LATENCY);
            bus_op   <= g_op;
            bus_addr <= g_addr;
            case (g_op)
              OP_UPGR:  state <= Q_UPGR;
              OP_FLUSH: state <= Q_WRITE;
              default:  state <= Q_READ;
            endcase
          end else if (tcnt == TW'(GRANT_TIMEOUT - 1)) begin
            cache_grant <= '0;
            state       <= Q_RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        Q_UPGR: begin
          bus_done <= 1'b1;
          state    <= Q_DONE;
        end
        Q_WRITE: begin
          mem[lat_addr] <= lat_data;
          bus_data      <= lat_data;
          bus_done      <= 1'b1;
          state         <= Q_DONE;
        end
        Q_READ: begin
          // A flush from an M holder beats memory, even on the expiry edge.
          if (iv_hit) begin
            mem[lat_addr] <= iv_data;
            bus_data      <= iv_data;
            bus_done      <= 1'b1;
            state         <= Q_DONE;
          end else if (lat_cnt == 4'd1) begin
            bus_data <= mem[lat_addr];
            bus_done <= 1'b1;
            state    <= Q_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        Q_DONE: begin
          bus_done    <= 1'b0;
          cache_grant <= '0;
          bus_op      <= OP_NONE;
          bus_addr    <= '0;
          state       <= Q_RELEASE;
        end
        Q_RELEASE: state <= Q_ARB;
        default:   state <= Q_ARB;
      endcase
    end
  end

endmodule

// File: doc/msi_bus_controller.md
# msi_bus_controller

Shared-bus arbiter and main-memory responder for the MSI snooping cache system. It grants the bus to one cache controller at a time and broadcasts that cache's operation and address to all snoopers. It services BusRd/BusRdX from a 32-line x 16-bit memory, or from a snooper's intervention flush, and absorbs BusFlush write-backs. It is the responder end of the protocol that each cache controller initiates.

## Interface
Parameters:
- NUM_CACHES, 2, number of attached cache controllers (2..4)
- MEM_LATENCY, 4, cycles in QRead before memory data is returned (1..15)
- GRANT_TIMEOUT, 16, cycles a grantee may hold the grant with bus_op None before the grant is revoked

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cache_req  in  NUM_CACHES  bus_request from each cache
- cache_op  in  3*NUM_CACHES  bus_op_out per cache, cache k at [3k+2:3k]
- cache_addr  in  5*NUM_CACHES  bus_addr_out per cache, line address {tag[2:0], cblk[1:0]}
- cache_data  in  16*NUM_CACHES  bus_dout per cache
- cache_done  in  NUM_CACHES  bus_done_out per cache, used for intervention flush
- cache_grant  out  NUM_CACHES  one-hot grant, at most one bit set
- bus_op  out  3  broadcast op: None=000, Rd=001, Upgr=010, Flush=011, RdX=100
- bus_addr  out  5  broadcast line address
- bus_data  out  16  line data, valid when bus_done=1
- bus_done  out  1  one-cycle completion pulse to all caches

## Operation
- All outputs are registered. Reset value of every output is 0 (bus_op = None).
- On reset, memory line i initializes to {3'b000, i[4:0], 3'b000, i[4:0]}. This applies to reset mid-transaction as well: grant drops, all state and the round-robin pointer clear, and any in-flight transaction is discarded without a memory write.
- States: QArb, QGrant, QUpgr, QWrite, QRead, QDone, QRelease.
- QArb: round-robin among cache_req. After reset, the pointer favours cache 0. The winner's grant goes high next cycle and the controller enters QGrant. Once a cache is served, it becomes lowest priority.
- QGrant: waits for the grantee's cache_op to be non-None. Latches op, addr and the grantee's cache_data on that edge.
  - Rd/RdX go to QRead.
  - Upgr goes to QUpgr.
  - Flush goes to QWrite.
  - If GRANT_TIMEOUT cycles pass with op None, go to QRelease without a done pulse.
- While in QUpgr, QWrite, QRead or QDone, bus_op and bus_addr hold the latched values. In all other states they are None/0.
- QUpgr: lasts 1 cycle so snoopers invalidate, then goes to QDone.
- QWrite: lasts 1 cycle. The latched data is written to mem[addr] at the end of the cycle, then goes to QDone. In QDone, bus_data equals the written data.
- QRead: a counter loads MEM_LATENCY.
  - Each cycle, if any non-grantee cache_done is high (intervention flush from an M holder), capture that cache's cache_data, write it to mem[addr], and go to QDone with that data. If several are high, the lowest index wins.
  - The grantee's cache_done is ignored.
  - When the counter expires with no intervention, bus_data is set to mem[addr] and the controller goes to QDone.
- QDone: bus_done=1 for exactly one cycle with bus_data valid, then QRelease.
- QRelease: one cycle with all grants 0 and bus_op None, then QArb. This gives the grantee time to drop cache_req.
- Non-grantee cache_op values are never broadcast. Requests from non-grantees stay pending.

## Timing
- cache_req sampled high in QArb at edge E leads to cache_grant high in the cycle after E.
- Op latched at edge L. bus_op is visible from cycle L+1.
- Upgr and Flush: bus_done is high in cycle L+2.
- Rd/RdX with no intervention: bus_done is high in cycle L+MEM_LATENCY+1.
- Intervention sampled at edge V: bus_done is high in cycle V+1.
- A mem write on Flush or intervention is visible to a read started in the next transaction.
- Minimum back-to-back spacing is grant to grant = transaction + QDone + QRelease + 1 arbitration cycle.
- Simultaneous events:
  - A reset edge overrides everything.
  - An intervention on the same edge the counter expires wins over memory data.

## Test plan
- Reset, then cache 0 issues Rd addr 5'd9 → grant[0] in 1 cycle; bus_op=001, bus_addr=9; bus_done pulse MEM_LATENCY+1 cycles after latch with bus_data=16'h0909; 1-cycle QRelease.
- Cache 1 issues Flush addr 3 with data 16'hBEEF, then cache 0 issues Rd addr 3 → bus_done 2 cycles after latch; the subsequent Rd returns 16'hBEEF.
- Cache 0 issues RdX addr 12 while cache 1 asserts cache_done with 16'hCAFE in the 2nd QRead cycle → bus_done the next cycle with 16'hCAFE; a later Rd of addr 12 returns 16'hCAFE.
- Both caches hold cache_req continuously → grants alternate 0,1,0,1; never two grant bits set.
- Grantee holds op None for GRANT_TIMEOUT cycles → grant drops, no bus_done, the other requester is granted next.
- Reset asserted mid-QRead → next cycle: all outputs 0, state QArb, memory restored to the init pattern (addr 3 reads 16'h0303).
